// File: rtl/jtopl_mixn.sv
// N-channel gain mixer for OPL-family cores: snapshot, serial multiply-accumulate, saturate.
// Optional peak/clip metering is compiled in when JTOPL_MIX_PEAK_EN is defined.
module jtopl_mixn #(
    parameter int CH   = 2,
    parameter int WIN  = 13,
    parameter int WOUT = 16,
    parameter int GW   = 8,
    localparam int AW  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cen,
    input  logic                   gain_we,
    input  logic [AW-1:0]          gain_addr,
    input  logic [GW-1:0]          gain_din,
    input  logic [CH*WIN-1:0]      snd_in,
    input  logic                   sample_in,
    output logic signed [WOUT-1:0] snd_out,
    output logic                   sample_out,
    output logic                   busy
`ifdef JTOPL_MIX_PEAK_EN
    ,
    input  logic                   clip_clr,
    output logic                   clip,
    output logic [WOUT-2:0]        peak
`endif
);

    localparam int CW  = (CH > 1) ? $clog2(CH) : 0;
    localparam int ACW = WIN + GW + CW + 1;
    localparam int PW  = WIN + GW + 1;
    localparam longint MAXL = (longint'(1) <<< (WOUT - 1)) - 1;
    localparam longint MINL = -(longint'(1) <<< (WOUT - 1));

    typedef enum logic [1:0] {IDLE, ACC, SAT} state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          idx_q, idx_d;
    logic signed [ACW-1:0]  acc_q, acc_d;
    logic signed [WIN-1:0]  snap_q [CH];
    logic signed [WIN-1:0]  snap_d [CH];
    logic [GW-1:0]          gain_q [CH];
    logic [GW-1:0]          gain_d [CH];
    logic signed [WOUT-1:0] snd_out_q, snd_out_d;
    logic                   sample_out_q, sample_out_d;

    logic signed [PW-1:0]   prod;
    logic signed [ACW-1:0]  shr;
    logic                   sat_hi, sat_lo;
    logic signed [WOUT-1:0] sat_val;

    // Gain is zero-extended so the product stays a signed-by-unsigned multiply.
    always_comb begin
        prod    = snap_q[idx_q] * $signed({1'b0, gain_q[idx_q]});
        shr     = acc_q >>> (GW - 1);
        sat_hi  = longint'(shr) > MAXL;
        sat_lo  = longint'(shr) < MINL;
        if (sat_hi)      sat_val = WOUT'(MAXL);
        else if (sat_lo) sat_val = WOUT'(MINL);
        else             sat_val = WOUT'(shr);
    end

`ifdef JTOPL_MIX_PEAK_EN
    logic                   clip_q, clip_d;
    logic [WOUT-2:0]        peak_q, peak_d;
    logic [WOUT-2:0]        mag;
    logic signed [WOUT-1:0] neg_val;

    // The most negative code has no positive twin, so it reports full scale.
    always_comb begin
        neg_val = -sat_val;
        if (!sat_val[WOUT-1])            mag = sat_val[WOUT-2:0];
        else if (longint'(sat_val) == MINL) mag = '1;
        else                             mag = neg_val[WOUT-2:0];
    end
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        snap_d       = snap_q;
        gain_d       = gain_q;
        snd_out_d    = snd_out_q;
        sample_out_d = 1'b0;
`ifdef JTOPL_MIX_PEAK_EN
        clip_d       = clip_q;
        peak_d       = peak_q;
`endif
        if (cen) begin
            if (gain_we && (int'(gain_addr) < CH))
                gain_d[gain_addr] = gain_din;
`ifdef JTOPL_MIX_PEAK_EN
            if (clip_clr) begin
                clip_d = 1'b0;
                peak_d = '0;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (sample_in) begin
                        for (int unsigned i = 0; i < CH; i++)
                            snap_d[i] = snd_in[i*WIN +: WIN];
                        acc_d   = '0;
                        idx_d   = '0;
                        state_d = ACC;
                    end
                end
                ACC: begin
                    acc_d = acc_q + ACW'(prod);
                    if (idx_q == AW'(CH - 1)) state_d = SAT;
                    else                      idx_d   = idx_q + AW'(1);
                end
                SAT: begin
                    snd_out_d    = sat_val;
                    sample_out_d = 1'b1;
                    state_d      = IDLE;
`ifdef JTOPL_MIX_PEAK_EN
                    if (sat_hi || sat_lo) clip_d = 1'b1;
                    if (mag > peak_d)     peak_d = mag;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            acc_q        <= '0;
            snd_out_q    <= '0;
            sample_out_q <= 1'b0;
            for (int unsigned i = 0; i < CH; i++) begin
                snap_q[i] <= '0;
                gain_q[i] <= GW'(1 << (GW - 1));
            end
`ifdef JTOPL_MIX_PEAK_EN
            clip_q       <= 1'b0;
            peak_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            snd_out_q    <= snd_out_d;
            sample_out_q <= sample_out_d;
            for (int unsigned i = 0; i < CH; i++) begin
                snap_q[i] <= snap_d[i];
                gain_q[i] <= gain_d[i];
            end
`ifdef JTOPL_MIX_PEAK_EN
            clip_q       <= clip_d;
            peak_q       <= peak_d;
`endif
        end
    end

    assign snd_out    = snd_out_q;
    assign sample_out = sample_out_q;
    assign busy       = (state_q != IDLE);
`ifdef JTOPL_MIX_PEAK_EN
    assign clip       = clip_q;
    assign peak       = peak_q;
`endif

endmodule

// File: tb/tb_jtopl_mixn.sv
// Directed + randomized bench for jtopl_mixn; two instances share inputs (WOUT=16 and WOUT=13).
// Peak/clip checks are active when JTOPL_MIX_PEAK_EN is defined.
module tb_jtopl_mixn;

    logic               clk = 1'b0;
    logic               rst_n, cen, gain_we, sample_in;
    logic [0:0]         gain_addr;
    logic [7:0]         gain_din;
    logic [25:0]        snd_in;
    logic signed [15:0] so16;
    logic signed [12:0] so13;
    logic               sp16, sp13, b16, b13;
`ifdef JTOPL_MIX_PEAK_EN
    logic               clip_clr, clip16, clip13;
    logic [14:0]        pk16;
    logic [11:0]        pk13;
    longint             pk16m, pk13m;
    bit                 clip16m, clip13m;
`endif

    always #5 clk = ~clk;

    jtopl_mixn #(.CH(2), .WIN(13), .WOUT(16), .GW(8)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .gain_we(gain_we), .gain_addr(gain_addr),
        .gain_din(gain_din), .snd_in(snd_in), .sample_in(sample_in),
        .snd_out(so16), .sample_out(sp16), .busy(b16)
`ifdef JTOPL_MIX_PEAK_EN
        , .clip_clr(clip_clr), .clip(clip16), .peak(pk16)
`endif
    );

    jtopl_mixn #(.CH(2), .WIN(13), .WOUT(13), .GW(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .cen(cen), .gain_we(gain_we), .gain_addr(gain_addr),
        .gain_din(gain_din), .snd_in(snd_in), .sample_in(sample_in),
        .snd_out(so13), .sample_out(sp13), .busy(b13)
`ifdef JTOPL_MIX_PEAK_EN
        , .clip_clr(clip_clr), .clip(clip13), .peak(pk13)
`endif
    );

    int checks = 0;
    int errors = 0;
    int gm [2];
    bit cen_alt = 1'b0;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Mixed value before saturation: weighted sum divided by unity gain, rounded toward -inf.
    function automatic longint raw_mix(input int a, input int b);
        longint s;
        s = longint'(a) * gm[0] + longint'(b) * gm[1];
        if (s >= 0) return s / 128;
        return -((-s + 127) / 128);
    endfunction

    function automatic longint clampw(input longint v, input int w);
        longint hi, lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic model_peak(input longint raw);
`ifdef JTOPL_MIX_PEAK_EN
        longint c, m;
        c = clampw(raw, 16);
        if (c != raw) clip16m = 1'b1;
        m = (c == -32768) ? 32767 : ((c < 0) ? -c : c);
        if (m > pk16m) pk16m = m;
        c = clampw(raw, 13);
        if (c != raw) clip13m = 1'b1;
        m = (c == -4096) ? 4095 : ((c < 0) ? -c : c);
        if (m > pk13m) pk13m = m;
`else
        if (raw == 0) return;
`endif
    endtask

    task automatic tick();
        @(negedge clk);
        if (cen_alt) cen = ~cen;
    endtask

    task automatic set_gain(input int ch, input int v);
        gain_we   = 1'b1;
        gain_addr = 1'(ch);
        gain_din  = 8'(v);
        tick();
        gain_we   = 1'b0;
        gm[ch]    = v;
    endtask

    task automatic do_mix(input int a, input int b, input int lat, input string tag);
        longint raw;
        int cnt;
        bit seen, pc;
        raw       = raw_mix(a, b);
        snd_in    = {13'(b), 13'(a)};
        sample_in = 1'b1;
        cnt = 0;
        seen = 1'b0;
        while (!seen && cnt < 24) begin
            pc = cen;
            tick();
            cnt++;
            if (pc) sample_in = 1'b0;
            if (sp16) seen = 1'b1;
        end
        sample_in = 1'b0;
        model_peak(raw);
        chk({tag, " latency"}, cnt, lat);
        chk({tag, " strobe13"}, sp13, 1);
        chk({tag, " out16"}, so16, clampw(raw, 16));
        chk({tag, " out13"}, so13, clampw(raw, 13));
        chk({tag, " busy done"}, b16, 0);
        tick();
        chk({tag, " strobe width"}, sp16, 0);
    endtask

    initial begin
        longint e;
        int cnt, a, b;
        rst_n = 1'b0; cen = 1'b1; gain_we = 1'b0; gain_addr = '0; gain_din = '0;
        snd_in = '0; sample_in = 1'b0;
        gm[0] = 128; gm[1] = 128;
`ifdef JTOPL_MIX_PEAK_EN
        clip_clr = 1'b0; pk16m = 0; pk13m = 0; clip16m = 0; clip13m = 0;
`endif
        repeat (3) tick();
        chk("reset out", so16, 0);
        chk("reset strobe", sp16, 0);
        chk("reset busy", b16, 0);
        rst_n = 1'b1;
        tick();

        do_mix(1000, -300, 4, "unity");
        chk("unity value", so16, 700);

        set_gain(0, 8'h40);
        do_mix(1000, 0, 4, "half gain");
        chk("half gain value", so16, 500);
        set_gain(0, 8'h80);
        set_gain(1, 8'hFF);
        do_mix(0, -1, 4, "floor");
        chk("floor value", so16, -2);

        // Reset in the middle of an accumulation.
        set_gain(0, 8'h40);
        snd_in = {13'(-300), 13'(1000)};
        sample_in = 1'b1;
        tick();
        sample_in = 1'b0;
        chk("busy in acc", b16, 1);
        rst_n = 1'b0;
        #1;
        chk("midmix reset out", so16, 0);
        chk("midmix reset busy", b16, 0);
        cnt = 0;
        repeat (5) begin tick(); if (sp16) cnt++; end
        chk("midmix reset no strobe", cnt, 0);
        gm[0] = 128; gm[1] = 128;
`ifdef JTOPL_MIX_PEAK_EN
        pk16m = 0; pk13m = 0; clip16m = 0; clip13m = 0;
`endif
        rst_n = 1'b1;
        tick();
        do_mix(1000, -300, 4, "gains after reset");

        // Overlapping strobes and a gain write on the channel being read.
        e = raw_mix(200, 300);
        snd_in = {13'(300), 13'(200)};
        sample_in = 1'b1;
        tick();
        snd_in = {13'(-4000), 13'(-4000)};
        tick();
        sample_in = 1'b0;
        gain_we = 1'b1; gain_addr = 1'b1; gain_din = 8'h20;
        tick();
        gain_we = 1'b0;
        snd_in = {13'(100), 13'(100)};
        sample_in = 1'b1;
        tick();
        sample_in = 1'b0;
        model_peak(e);
        chk("overlap strobe", sp16, 1);
        chk("overlap value", so16, clampw(e, 16));
        gm[1] = 8'h20;
        cnt = 0;
        repeat (10) begin tick(); if (sp16) cnt++; end
        chk("overlap no extra strobe", cnt, 0);
        chk("overlap idle", b16, 0);
        do_mix(200, 300, 4, "new gain");

`ifdef JTOPL_MIX_PEAK_EN
        clip_clr = 1'b1; tick(); clip_clr = 1'b0;
        pk16m = 0; pk13m = 0; clip16m = 0; clip13m = 0;
`endif
        set_gain(0, 8'hFF);
        set_gain(1, 8'hFF);
        do_mix(4095, 4095, 4, "sat pos");
        chk("sat pos 13", so13, 4095);
        do_mix(-4096, -4096, 4, "sat neg");
        chk("sat neg 13", so13, -4096);
`ifdef JTOPL_MIX_PEAK_EN
        chk("clip13", clip13, 1);
        chk("peak13", pk13, 4095);
        chk("clip16", clip16, clip16m);
        chk("peak16", pk16, pk16m);
        chk("peak13 model", pk13, pk13m);
        clip_clr = 1'b1; tick(); clip_clr = 1'b0;
        chk("clip13 cleared", clip13, 0);
        chk("peak13 cleared", pk13, 0);
        pk16m = 0; pk13m = 0; clip16m = 0; clip13m = 0;
`endif

        for (int k = 0; k < 6; k++) begin
            set_gain(0, int'($urandom_range(255)));
            set_gain(1, int'($urandom_range(255)));
            a = int'($urandom_range(8191)) - 4096;
            b = int'($urandom_range(8191)) - 4096;
            do_mix(a, b, 4, "random");
        end

        // Clock enable every other cycle, starting on a disabled cycle.
        a = int'($urandom_range(8191)) - 4096;
        b = int'($urandom_range(8191)) - 4096;
        cen_alt = 1'b1;
        cen = 1'b0;
        do_mix(a, b, 8, "half cen");
        cen_alt = 1'b0;
        cen = 1'b1;
        tick();
`ifdef JTOPL_MIX_PEAK_EN
        chk("final peak16", pk16, pk16m);
        chk("final clip13", clip13, clip13m);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
